// File: rtl/seq_tx_1110_if.sv
// Request and serial-stream signals of the 1110 pattern transmitter.
// master: the side that issues requests; slave: the transmitter itself.
interface seq_tx_1110_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic             use_ext;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x_out;
    logic             x_vld;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_cnt;

    modport master (
        output start, use_ext, pat_in, reps, gap,
        input  x_out, x_vld, busy, done, sent_cnt
    );

    modport slave (
        input  start, use_ext, pat_in, reps, gap,
        output x_out, x_vld, busy, done, sent_cnt
    );
endinterface

// File: rtl/seq_tx_1110.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first, reps times, gap idle bits apart.
// Optional SEQ_TX_PARITY_EN appends an even-parity bit to every copy.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | shifting pattern bits out, one per clk
// PAR   | parity bit after the LSB (SEQ_TX_PARITY_EN only)
// GAP   | idle 0 bits between copies, timed by a down-counter
// DONE  | single-cycle done pulse, then IDLE
module seq_tx_1110 #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1110,
    parameter int               CNT_W   = 4,
    parameter int               GAP_W   = 3
) (
    input logic         clk,
    input logic         rst,
    seq_tx_1110_if.slave tx
);
    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEND = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef SEQ_TX_PARITY_EN
    localparam logic [2:0] PAR  = 3'd4;
`endif

    logic [2:0]       state_q, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [PAT_W-1:0] sh_q, sh_n;
    logic [CNT_W-1:0] reps_q, reps_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic [GAP_W-1:0] gcnt_q, gcnt_n;
    logic [BIT_W-1:0] bit_q, bit_n;
    logic [CNT_W-1:0] sent_q, sent_n;
    logic             x_out_q, x_out_n;
    logic             x_vld_q, x_vld_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             copy_end;
    logic [CNT_W-1:0] sent_inc;
    logic [PAT_W-1:0] pat_sel;

    assign sent_inc = sent_q + CNT_W'(1);
    assign pat_sel  = tx.use_ext ? tx.pat_in : PATTERN;

    always_comb begin
        state_n  = state_q;
        pat_n    = pat_q;
        sh_n     = sh_q;
        reps_n   = reps_q;
        gap_n    = gap_q;
        gcnt_n   = gcnt_q;
        bit_n    = bit_q;
        sent_n   = sent_q;
        x_out_n  = 1'b0;
        x_vld_n  = 1'b0;
        busy_n   = busy_q;
        done_n   = 1'b0;
        copy_end = 1'b0;

        case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                if (tx.start) begin
                    pat_n  = pat_sel;
                    reps_n = tx.reps;
                    gap_n  = tx.gap;
                    sent_n = '0;
                    busy_n = 1'b1;
                    if (tx.reps != '0) begin
                        state_n = SEND;
                        sh_n    = pat_sel;
                        bit_n   = LAST_BIT;
                        x_out_n = pat_sel[PAT_W-1];
                        x_vld_n = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bit_q != '0) begin
                    sh_n    = sh_q << 1;
                    bit_n   = bit_q - BIT_W'(1);
                    x_out_n = sh_q[PAT_W-2];
                    x_vld_n = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_n = PAR;
                    x_out_n = ^pat_q;
                    x_vld_n = 1'b1;
`else
                    copy_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: copy_end = 1'b1;
`endif
            GAP: begin
                if (gcnt_q == '0) begin
                    state_n = SEND;
                    sh_n    = pat_q;
                    bit_n   = LAST_BIT;
                    x_out_n = pat_q[PAT_W-1];
                    x_vld_n = 1'b1;
                end else begin
                    gcnt_n = gcnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Copy boundary: finish, restart back-to-back, or time out the gap.
        if (copy_end) begin
            sent_n = sent_inc;
            if (sent_inc == reps_q) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else if (gap_q == '0) begin
                state_n = SEND;
                sh_n    = pat_q;
                bit_n   = LAST_BIT;
                x_out_n = pat_q[PAT_W-1];
                x_vld_n = 1'b1;
            end else begin
                state_n = GAP;
                gcnt_n  = gap_q - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            bit_q   <= '0;
            sent_q  <= '0;
            x_out_q <= 1'b0;
            x_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            sh_q    <= sh_n;
            reps_q  <= reps_n;
            gap_q   <= gap_n;
            gcnt_q  <= gcnt_n;
            bit_q   <= bit_n;
            sent_q  <= sent_n;
            x_out_q <= x_out_n;
            x_vld_q <= x_vld_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign tx.x_out    = x_out_q;
    assign tx.x_vld    = x_vld_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
    assign tx.sent_cnt = sent_q;
endmodule
